// File: rtl/gcd_unit.sv
// gcd_unit: greatest-common-divisor engine built from Euclid's subtract/swap
// algorithm, with a valid/ready input handshake and a held result.
// It performs one swap or one subtract per clock. It also counts the
// operations so that performance can be checked against a reference model.

module gcd_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   input  logic             result_taken,
   output logic [WIDTH:0]   iter_count
);

   // Two-bit encoding leaves one spare code (2'd3).
   // That code is steered back to IDLE.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH:0]   cnt;

   logic [WIDTH-1:0] a_next;
   logic [WIDTH-1:0] b_next;
   logic [WIDTH:0]   cnt_next;

   logic             a_lt_b;
   logic             b_zero;
   logic [WIDTH-1:0] a_minus_b;
   logic [WIDTH:0]   cnt_inc;

   // Datapath helpers.
   // The subtract result is only used when A >= B, so it never wraps.
   // The counter increment sticks at all-ones rather than rolling over.
   always_comb begin
      a_lt_b    = (a_reg < b_reg);
      b_zero    = (b_reg == '0);
      a_minus_b = a_reg - b_reg;
      cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
   end

   // Next-state and next-datapath logic.
   // Each register holds by default, and each state overrides only what it changes.
   always_comb begin
      state_next = state;
      a_next     = a_reg;
      b_next     = b_reg;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (in_valid) begin
               a_next     = a_in;
               b_next     = b_in;
               cnt_next   = '0;
               state_next = COMPUTE;
            end
         end
         COMPUTE: begin
            if (a_lt_b) begin
               a_next   = b_reg;
               b_next   = a_reg;
               cnt_next = cnt_inc;
            end else if (!b_zero) begin
               a_next   = a_minus_b;
               cnt_next = cnt_inc;
            end else begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (result_taken) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   // An asynchronous reset abandons any pair that is in flight.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Operand and counter registers.
   // Reset clears them so that result and iter_count read zero.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         a_reg <= '0;
         b_reg <= '0;
         cnt   <= '0;
      end else begin
         a_reg <= a_next;
         b_reg <= b_next;
         cnt   <= cnt_next;
      end
   end

   // Outputs are decoded from registers only.
   // This keeps every input-to-output path broken by a flop.
   always_comb begin
      in_ready   = (state == IDLE);
      out_valid  = (state == DONE);
      result     = a_reg;
      iter_count = cnt;
   end

endmodule

// File: tb/tb_gcd_unit.sv
// tb_gcd_unit: directed and exhaustive checks of gcd_unit.
// The first instance uses WIDTH=16 for the directed vectors.
// The second instance uses WIDTH=4 for the exhaustive sweep.

module tb_gcd_unit;

   localparam int LIMIT = 300;

   logic        clk;
   logic        nrst;

   logic        in_valid16;
   logic        in_ready16;
   logic [15:0] a_in16;
   logic [15:0] b_in16;
   logic        out_valid16;
   logic [15:0] result16;
   logic        result_taken16;
   logic [16:0] iter_count16;

   logic        in_valid4;
   logic        in_ready4;
   logic [3:0]  a_in4;
   logic [3:0]  b_in4;
   logic        out_valid4;
   logic [3:0]  result4;
   logic        result_taken4;
   logic [4:0]  iter_count4;

   int n_vec;
   int n_err;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_res;
      logic [16:0] exp_cnt;
   } vec_t;

   vec_t vecs[10];

   gcd_unit #(.WIDTH(16)) dut16 (
      .clk          (clk),
      .nrst         (nrst),
      .in_valid     (in_valid16),
      .in_ready     (in_ready16),
      .a_in         (a_in16),
      .b_in         (b_in16),
      .out_valid    (out_valid16),
      .result       (result16),
      .result_taken (result_taken16),
      .iter_count   (iter_count16)
   );

   gcd_unit #(.WIDTH(4)) dut4 (
      .clk          (clk),
      .nrst         (nrst),
      .in_valid     (in_valid4),
      .in_ready     (in_ready4),
      .a_in         (a_in4),
      .b_in         (b_in4),
      .out_valid    (out_valid4),
      .result       (result4),
      .result_taken (result_taken4),
      .iter_count   (iter_count4)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Present a pair to the 16-bit instance once it is ready.
   // Then count edges after the accepting edge until out_valid is seen.
   task automatic apply_stimulus16(input logic [15:0] a, input logic [15:0] b, output int lat);
      int guard;
      guard = 0;
      while (!in_ready16 && guard < LIMIT) begin
         @(negedge clk);
         guard++;
      end
      check("in_ready16 before accept", 32'(in_ready16), 32'd1);
      in_valid16 = 1'b1;
      a_in16     = a;
      b_in16     = b;
      @(negedge clk);
      in_valid16 = 1'b0;
      lat = 0;
      while (!out_valid16 && lat < LIMIT) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic check_output16(input string name, input int lat,
                                 input logic [15:0] exp_res, input logic [16:0] exp_cnt);
      check({name, " out_valid"}, 32'(out_valid16), 32'd1);
      check({name, " result"}, 32'(result16), 32'(exp_res));
      check({name, " iter_count"}, 32'(iter_count16), 32'(exp_cnt));
      check({name, " latency"}, 32'(lat), 32'(exp_cnt) + 32'd1);
   endtask

   task automatic take_result16(input string name);
      result_taken16 = 1'b1;
      @(negedge clk);
      result_taken16 = 1'b0;
      check({name, " out_valid after take"}, 32'(out_valid16), 32'd0);
      check({name, " in_ready after take"}, 32'(in_ready16), 32'd1);
   endtask

   // Reference GCD computed by the remainder form of Euclid's algorithm.
   function automatic logic [3:0] ref_gcd(input logic [3:0] a, input logic [3:0] b);
      int x, y, t;
      x = int'(a);
      y = int'(b);
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return 4'(x);
   endfunction

   // Count the swap and subtract operations that the subtract/swap algorithm takes.
   function automatic int ref_ops(input logic [3:0] a, input logic [3:0] b);
      int x, y, t, n;
      x = int'(a);
      y = int'(b);
      n = 0;
      while (1) begin
         if (x < y) begin
            t = x;
            x = y;
            y = t;
            n++;
         end else if (y != 0) begin
            x = x - y;
            n++;
         end else begin
            break;
         end
      end
      return n;
   endfunction

   // Run one pair through the 4-bit instance.
   // The result is taken after a random delay of 0 to 3 cycles.
   task automatic run_pair4(input logic [3:0] a, input logic [3:0] b);
      int guard;
      int lat;
      int dly;
      int exp_n;
      guard = 0;
      while (!in_ready4 && guard < LIMIT) begin
         @(negedge clk);
         guard++;
      end
      in_valid4 = 1'b1;
      a_in4     = a;
      b_in4     = b;
      @(negedge clk);
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      exp_n = ref_ops(a, b);
      check($sformatf("w4 (%0d,%0d) out_valid", a, b), 32'(out_valid4), 32'd1);
      check($sformatf("w4 (%0d,%0d) result", a, b), 32'(result4), 32'(ref_gcd(a, b)));
      check($sformatf("w4 (%0d,%0d) iter_count", a, b), 32'(iter_count4), 32'(exp_n));
      check($sformatf("w4 (%0d,%0d) latency", a, b), 32'(lat), 32'(exp_n + 1));
      dly = int'($urandom_range(0, 3));
      repeat (dly) @(negedge clk);
      result_taken4 = 1'b1;
      @(negedge clk);
      result_taken4 = 1'b0;
   endtask

   initial begin
      int lat;
      n_vec = 0;
      n_err = 0;

      vecs[0] = '{16'd12,    16'd8,     16'd4,     17'd5};
      vecs[1] = '{16'd0,     16'd0,     16'd0,     17'd0};
      vecs[2] = '{16'd9,     16'd0,     16'd9,     17'd0};
      vecs[3] = '{16'd0,     16'd7,     16'd7,     17'd1};
      vecs[4] = '{16'd21,    16'd14,    16'd7,     17'd5};
      vecs[5] = '{16'd1,     16'd1,     16'd1,     17'd2};
      vecs[6] = '{16'd100,   16'd75,    16'd25,    17'd6};
      vecs[7] = '{16'd7,     16'd3,     16'd1,     17'd7};
      vecs[8] = '{16'd65535, 16'd65535, 16'd65535, 17'd2};
      vecs[9] = '{16'd5,     16'd10,    16'd5,     17'd4};

      nrst           = 1'b0;
      in_valid16     = 1'b0;
      a_in16         = '0;
      b_in16         = '0;
      result_taken16 = 1'b0;
      in_valid4      = 1'b0;
      a_in4          = '0;
      b_in4          = '0;
      result_taken4  = 1'b0;

      #3;
      check("reset in_ready", 32'(in_ready16), 32'd1);
      check("reset out_valid", 32'(out_valid16), 32'd0);
      check("reset result", 32'(result16), 32'd0);
      check("reset iter_count", 32'(iter_count16), 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);

      // Table-driven vectors.
      for (int i = 0; i < 10; i++) begin
         apply_stimulus16(vecs[i].a, vecs[i].b, lat);
         check_output16($sformatf("vec%0d", i), lat, vecs[i].exp_res, vecs[i].exp_cnt);
         take_result16($sformatf("vec%0d", i));
      end

      // Back-pressure.
      // The result must stay stable while untaken, and in_valid during DONE must be ignored.
      apply_stimulus16(16'd12, 16'd8, lat);
      check_output16("bp", lat, 16'd4, 17'd5);
      in_valid16 = 1'b1;
      a_in16     = 16'd0;
      b_in16     = 16'd7;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp hold out_valid", 32'(out_valid16), 32'd1);
         check("bp hold in_ready", 32'(in_ready16), 32'd0);
         check("bp hold result", 32'(result16), 32'd4);
         check("bp hold iter_count", 32'(iter_count16), 32'd5);
      end
      result_taken16 = 1'b1;
      @(negedge clk);
      result_taken16 = 1'b0;
      check("bp idle out_valid", 32'(out_valid16), 32'd0);
      check("bp idle in_ready", 32'(in_ready16), 32'd1);
      @(negedge clk);
      in_valid16 = 1'b0;
      check("bp accepted in_ready", 32'(in_ready16), 32'd0);
      lat = 0;
      while (!out_valid16 && lat < LIMIT) begin
         @(negedge clk);
         lat++;
      end
      check_output16("bp second", lat, 16'd7, 17'd1);
      take_result16("bp second");

      // Reset asserted in the middle of a long computation.
      in_valid16 = 1'b1;
      a_in16     = 16'd65535;
      b_in16     = 16'd1;
      @(negedge clk);
      in_valid16 = 1'b0;
      repeat (20) @(negedge clk);
      check("midrst out_valid", 32'(out_valid16), 32'd0);
      check("midrst iter_count", 32'(iter_count16), 32'd20);
      check("midrst result", 32'(result16), 32'd65515);
      #2;
      nrst = 1'b0;
      #1;
      check("midrst in_ready", 32'(in_ready16), 32'd1);
      check("midrst out_valid now", 32'(out_valid16), 32'd0);
      check("midrst result now", 32'(result16), 32'd0);
      check("midrst iter_count now", 32'(iter_count16), 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      check("postrst out_valid", 32'(out_valid16), 32'd0);
      apply_stimulus16(16'd21, 16'd14, lat);
      check_output16("postrst", lat, 16'd7, 17'd5);
      take_result16("postrst");

      // Exhaustive sweep over every pair for WIDTH=4.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_pair4(4'(a), 4'(b));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
